mul_share_ctrl: RTL and testbench
=================================

# mul_share_ctrl

Sequencer and round-robin arbiter for the shared repeated-addition multiplier datapath (registers A, B, P; P <= P + A, B <= B - 1, eqz = (B == 0)). Up to N requesters each present an operand pair and a request. The block grants one requester at a time, steers its operands onto the datapath, and drives the datapath strobes ld_a/ld_b/clr_p/ld_p/dec_b. It captures the product and returns it with a one-cycle done pulse to the granted requester.

## Interface
- W, 8, operand width; product width is 2W
- N, 4, number of requesters (2..8)
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N  request per requester, level
- req_a  in  N*W  operand A per requester, slice i = bits [i*W +: W]
- req_b  in  N*W  operand B per requester, same slicing
- gnt  out  N  one-hot grant, registered; all-zero when idle
- done  out  N  one-cycle pulse to the granted requester; result valid this cycle
- result  out  2W  registered product, holds until the next capture
- busy  out  1  high in every state except IDLE
- op_a, op_b  out  W each  granted requester's operands, muxed by gnt; zero when gnt = 0
- ld_a, ld_b, clr_p, ld_p, dec_b  out  1 each  datapath strobes, combinational from state and eqz
- eqz  in  1  datapath B == 0
- prod  in  2W  datapath P register

## Operation
- States: IDLE, LD_A, LD_B, ADD, DONE.
- IDLE:
  - No strobes.
  - If any req is high, pick the winner round-robin: search starts at ptr+1 and wraps modulo N.
  - On the edge: gnt <= onehot(winner), ptr <= winner, go to LD_A.
- LD_A: ld_a = 1. Next state LD_B.
- LD_B: ld_b = 1, clr_p = 1. Next state ADD.
- ADD:
  - ld_p = dec_b = !eqz.
  - While eqz = 0, stay in ADD.
  - When eqz = 1, result <= prod and go to DONE.
- DONE: done[winner] = 1. On the edge: gnt <= 0, go to IDLE.
- Operands: op_a/op_b are driven from the granted slice throughout LD_A..DONE. The requester must hold req_a/req_b stable until done.
- Request deasserted mid-operation: ignored. The operation completes and done still pulses.
- Request still high in the IDLE cycle after DONE: treated as a new request. Requesters drop req on the edge where they sample done = 1.
- B = 0: eqz is already high on the first ADD cycle, so ADD lasts 1 cycle, there are no ld_p/dec_b pulses, and result = 0.
- Arithmetic: the product of two W-bit values fits in 2W bits, so no overflow handling is required.
- Reset (any time, including mid-ADD):
  - state = IDLE, gnt = 0, done = 0, result = 0, busy = 0, ptr = N-1 (requester 0 wins first).
  - All strobes low; op_a = op_b = 0.
  - The datapath is reinitialised by the next LD_A/LD_B.

## Timing
- Acceptance edge: the edge leaving IDLE. Call the following cycle cycle 1.
- Cycle 1 is LD_A, cycle 2 is LD_B, cycles 3..B+3 are ADD, cycle B+4 is DONE.
- Latency from acceptance edge to done pulse: B+4 cycles. Minimum 4 (B = 0); maximum 2^W + 3.
- Exactly B cycles carry ld_p = dec_b = 1.
- Throughput: one IDLE cycle between operations, so back-to-back service starts B+5 cycles apart.
- gnt and busy rise on the acceptance edge and fall on the edge after DONE.
- result changes only on the ADD→DONE edge.
- Simultaneous requests: exactly one grant. The next grant goes to the nearest requesting index above the last winner. No requester waits more than N-1 operations.

## Test plan
- Single request: req[0] with a = 5, b = 3.
  - done[0] pulses at cycle 7.
  - result = 15.
  - Exactly 3 ld_p and 3 dec_b pulses.
  - gnt = 0001 during cycles 1..7.
- Zero operand: req[1] with a = 9, b = 0.
  - done[1] at cycle 4, result = 0, no ld_p pulses.
  - Also a = 0, b = 4: result = 0, 4 ld_p pulses.
- Contention: req[0], req[2] and req[3] held continuously from reset.
  - Grant order is 0, 2, 3, 0, 2, ...
  - Each done goes to the matching index; no gnt overlap; one IDLE cycle between grants.
- Maximum values: a = 255, b = 255 (W = 8).
  - result = 65025.
  - done at cycle 259.
  - busy high for 259 cycles.
- Reset mid-operation: assert rst_n = 0 in the 5th ADD cycle of a = 7, b = 10.
  - Asynchronously: gnt = 0, busy = 0, strobes low, result = 0.
  - After release with req[2] high: requester 2 is served, result = 70.
- Request drop: req[1] with a = 6, b = 2, deasserted in cycle 3.
  - Operation still completes; done[1] at cycle 6, result = 12.
  - No re-grant to requester 1.

Source files
------------

// File: rtl/mul_share_ctrl.sv
// Round-robin sequencer for a shared repeated-addition multiplier: grants one requester,
// steers its operands, drives the datapath strobes. Done pulses B+4 cycles after acceptance.
module mul_share_ctrl #(
  parameter int W = 8,
  parameter int N = 4   // 2..8 requesters
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [2*W-1:0] result,
  output logic           busy,
  output logic [W-1:0]   op_a,
  output logic [W-1:0]   op_b,
  output logic           ld_a,
  output logic           ld_b,
  output logic           clr_p,
  output logic           ld_p,
  output logic           dec_b,
  input  logic           eqz,
  input  logic [2*W-1:0] prod
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0] NUM = (PW+1)'(N);

  typedef enum logic [2:0] {IDLE, LD_A, LD_B, ADD, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr, win;
  logic [PW:0]   idx;
  logic          found;

  // Search starts just above the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= NUM) idx = idx - NUM;
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    clr_p     = 1'b0;
    ld_p      = 1'b0;
    dec_b     = 1'b0;
    case (state)
      IDLE: if (found) state_nxt = LD_A;
      LD_A: begin
        ld_a      = 1'b1;
        state_nxt = LD_B;
      end
      LD_B: begin
        ld_b      = 1'b1;
        clr_p     = 1'b1;
        state_nxt = ADD;
      end
      ADD: begin
        ld_p  = !eqz;
        dec_b = !eqz;
        if (eqz) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      ptr    <= PW'(N - 1);
      result <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        gnt <= {{(N-1){1'b0}}, 1'b1} << win;
        ptr <= win;
      end else if (state == DONE) begin
        gnt <= '0;
      end
      if (state == ADD && eqz) result <= prod;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE) ? gnt : '0;

  // gnt is one-hot or zero, so OR-ing the gated slices is a plain mux.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        op_a = op_a | req_a[i*W +: W];
        op_b = op_b | req_b[i*W +: W];
      end
    end
  end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: models the shared datapath and checks products, timing and grant order.
module tb_mul_share_ctrl;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   gnt, done;
  logic [2*W-1:0] result;
  logic           busy;
  logic [W-1:0]   op_a, op_b;
  logic           ld_a, ld_b, clr_p, ld_p, dec_b;
  logic           eqz;
  logic [2*W-1:0] prod;

  logic [W-1:0]   dp_a = '0, dp_b = '0;
  logic [2*W-1:0] dp_p = '0;

  int checks = 0;
  int failures = 0;
  int ref_ptr;
  int last_result;
  int opa [N];
  int opb [N];

  mul_share_ctrl #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .op_a(op_a), .op_b(op_b), .ld_a(ld_a), .ld_b(ld_b), .clr_p(clr_p),
    .ld_p(ld_p), .dec_b(dec_b), .eqz(eqz), .prod(prod)
  );

  always #5 clk = ~clk;

  // Shared datapath the controller sequences.
  always @(posedge clk) begin
    if (ld_a) dp_a <= op_a;
    if (ld_b) dp_b <= op_b;
    if (dec_b) dp_b <= dp_b - 8'd1;
    if (clr_p) dp_p <= '0;
    else if (ld_p) dp_p <= dp_p + {8'd0, dp_a};
  end
  assign eqz  = (dp_b == '0);
  assign prod = dp_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    opa[i] = a;
    opb[i] = b;
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  // Waits for the next grant and follows the operation to its done pulse and the IDLE cycle after.
  task automatic serve(input bit drop, input int drop_cyc, input bit chk_gap);
    int w, a, b, cyc, wait_n, nldp, ndec, nbusy;
    bit gok, ook, sok, rok;
    w = rr_pick(req, ref_ptr);
    if (w < 0) w = 0;
    a = opa[w];
    b = opb[w];
    wait_n = 0;
    @(negedge clk);
    while (gnt == '0 && wait_n < 40) begin
      wait_n++;
      @(negedge clk);
    end
    chk("grant", 32'(gnt), 32'(1 << w));
    if (chk_gap) chk("idle_gap", wait_n, 0);
    if (gnt == '0) return;
    ref_ptr = w;
    cyc = 1; nldp = 0; ndec = 0; nbusy = 0;
    gok = 1; ook = 1; sok = 1; rok = 1;
    while (1) begin
      if (gnt !== N'(1 << w)) gok = 0;
      if (op_a !== W'(a) || op_b !== W'(b)) ook = 0;
      if (ld_a !== (cyc == 1) || ld_b !== (cyc == 2) || clr_p !== (cyc == 2)) sok = 0;
      if (ld_p !== dec_b || (ld_p && cyc < 3)) sok = 0;
      if (ld_p) nldp++;
      if (dec_b) ndec++;
      if (busy) nbusy++;
      if (done != '0) break;
      if (result !== 16'(last_result)) rok = 0;
      if (cyc == drop_cyc) req[w] = 1'b0;
      if (cyc > 300) break;
      @(negedge clk);
      cyc++;
    end
    chk("done_vec", 32'(done), 32'(1 << w));
    chk("latency", cyc, b + 4);
    chk("result", 32'(result), a * b);
    chk("ld_p_count", nldp, b);
    chk("dec_b_count", ndec, b);
    chk("busy_cycles", nbusy, b + 4);
    chk("gnt_stable", gok, 1);
    chk("operands", ook, 1);
    chk("strobe_seq", sok, 1);
    chk("result_hold", rok, 1);
    last_result = a * b;
    if (drop) req[w] = 1'b0;
    @(negedge clk);
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int mask, nops, quiet, cyc;
    rst_n = 1'b0;
    req = '0;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) set_op(i, 0, 0);
    ref_ptr = N - 1;
    last_result = 0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_strobes", {ld_a, ld_b, clr_p, ld_p, dec_b}, 0);
    chk("rst_ops", {op_a, op_b}, 0);
    rst_n = 1'b1;

    // Single request.
    set_op(0, 5, 3); req[0] = 1'b1;
    serve(1, 0, 0);

    // Zero operands.
    set_op(1, 9, 0); req[1] = 1'b1;
    serve(1, 0, 0);
    set_op(1, 0, 4); req[1] = 1'b1;
    serve(1, 0, 0);

    // Contention held from reset: order 0,2,3,0,2,3 from the model.
    rst_n = 1'b0;
    ref_ptr = N - 1;
    last_result = 0;
    set_op(0, $urandom_range(0, 255), $urandom_range(0, 12));
    set_op(2, $urandom_range(0, 255), $urandom_range(0, 12));
    set_op(3, $urandom_range(0, 255), $urandom_range(0, 12));
    req = 4'b1101;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) serve(0, 0, k != 0);
    req = '0;

    // Maximum operands.
    set_op(3, 255, 255); req[3] = 1'b1;
    serve(1, 0, 0);

    // Reset in the 5th ADD cycle.
    set_op(0, 7, 10); req[0] = 1'b1;
    cyc = 0;
    while (gnt == '0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    repeat (6) @(negedge clk);
    chk("midop_ldp", ld_p, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_result", 32'(result), 0);
    chk("arst_strobes", {ld_a, ld_b, clr_p, ld_p, dec_b}, 0);
    chk("arst_ops", {op_a, op_b}, 0);
    req = '0;
    set_op(2, 7, 10); req[2] = 1'b1;
    ref_ptr = N - 1;
    last_result = 0;
    @(negedge clk);
    rst_n = 1'b1;
    serve(1, 0, 0);

    // Request dropped in cycle 3.
    set_op(1, 6, 2); req[1] = 1'b1;
    serve(0, 3, 0);
    quiet = 1;
    repeat (5) begin
      @(negedge clk);
      if (gnt != '0 || busy) quiet = 0;
    end
    chk("no_regrant", quiet, 1);

    // Random request masks and operands.
    for (int r = 0; r < 5; r++) begin
      mask = $urandom_range(1, (1 << N) - 1);
      for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 255), $urandom_range(0, 30));
      req = N'(mask);
      nops = 0;
      while (req != '0 && nops < N) begin
        serve(1, 0, 0);
        nops++;
      end
      chk("rand_drained", 32'(req), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
